alu_operand_stage: RTL

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

---
 rtl/alu_pkg.sv | 30 +++
 rtl/barrel_shifter.sv | 127 ++++++++++++
 rtl/alu_operand_stage.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU operand stage: shift encodings, FSM states and
// the operand bundle held while a register-specified shift is pending.
package alu_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_type_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_REGSHIFT = 2'b01,
    ST_HOLD     = 2'b10
  } state_e;

  // Everything a register-shift operation needs one cycle after acceptance.
  typedef struct packed {
    logic [31:0] rn;
    logic [31:0] rm;
    logic [7:0]  rs;
    shift_type_e shift_type;
    logic [4:0]  cmd;
    logic        cin;
  } operand_t;

  localparam operand_t OPERAND_RESET = '0;

endpackage

// File: rtl/barrel_shifter.sv
// Combinational operand-2 shifter. is_reg=0 applies the immediate-shift
// encodings (#0 means #32 / RRX); is_reg=1 applies register-amount rules on
// the full 8-bit amount. Rotated immediates use is_reg=1 with ROR.
module barrel_shifter
  import alu_pkg::*;
(
  input  logic [31:0] value,
  input  shift_type_e shift_type,
  input  logic [7:0]  amount,
  input  logic        carry_in,
  input  logic        is_reg,
  output logic [31:0] result,
  output logic        carry,
  output logic        shifted
);

  logic [4:0]         n;
  logic [32:0]        lsl_ext;
  logic [32:0]        rsh_ext;
  logic signed [32:0] asr_ext;
  logic [31:0]        rot_res;
  logic               amt_zero;
  logic               amt_lt32;
  logic               amt_eq32;

  // Shared shift results; the extra bit carries the last bit shifted out.
  always_comb begin
    n        = amount[4:0];
    lsl_ext  = {1'b0, value} << n;
    rsh_ext  = {value, 1'b0} >> n;
    asr_ext  = $signed({value, 1'b0}) >>> n;
    rot_res  = (value >> n) | (value << (6'd32 - {1'b0, n}));
    amt_zero = (amount == 8'd0);
    amt_lt32 = (amount < 8'd32);
    amt_eq32 = (amount == 8'd32);
  end

  // Select result/carry according to encoding and amount range.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    result  = value;
    carry   = carry_in;
    shifted = 1'b0;
    if (!is_reg) begin
      unique case (shift_type)
        SH_LSL: begin
          if (n != 5'd0) begin
            result  = lsl_ext[31:0];
            carry   = lsl_ext[32];
            shifted = 1'b1;
          end
        end
        SH_LSR: begin
          shifted = 1'b1;
          if (n == 5'd0) begin
            result = 32'd0;
            carry  = value[31];
          end else begin
            result = rsh_ext[32:1];
            carry  = rsh_ext[0];
          end
        end
        SH_ASR: begin
          shifted = 1'b1;
          if (n == 5'd0) begin
            result = {32{value[31]}};
            carry  = value[31];
          end else begin
            result = asr_ext[32:1];
            carry  = asr_ext[0];
          end
        end
        SH_ROR: begin
          shifted = 1'b1;
          if (n == 5'd0) begin
            result = {carry_in, value[31:1]};
            carry  = value[0];
          end else begin
            result = rot_res;
            carry  = rot_res[31];
          end
        end
      endcase
    end else if (!amt_zero) begin
      shifted = 1'b1;
      unique case (shift_type)
        SH_LSL: begin
          if (amt_lt32) begin
            result = lsl_ext[31:0];
            carry  = lsl_ext[32];
          end else begin
            result = 32'd0;
            carry  = amt_eq32 ? value[0] : 1'b0;
          end
        end
        SH_LSR: begin
          if (amt_lt32) begin
            result = rsh_ext[32:1];
            carry  = rsh_ext[0];
          end else begin
            result = 32'd0;
            carry  = amt_eq32 ? value[31] : 1'b0;
          end
        end
        SH_ASR: begin
          if (amt_lt32) begin
            result = asr_ext[32:1];
            carry  = asr_ext[0];
          end else begin
            result = {32{value[31]}};
            carry  = value[31];
          end
        end
        SH_ROR: begin
          if (n == 5'd0) begin
            result = value;
            carry  = value[31];
          end else begin
            result = rot_res;
            carry  = rot_res[31];
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand stage between decode and ALU. Immediate and immediate-shift
// operations produce registered operands one cycle after acceptance;
// register-amount shifts spend one extra cycle in REGSHIFT.
module alu_operand_stage
  import alu_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] rn_val,
  input  logic [31:0] rm_val,
  input  logic [7:0]  rs_val,
  input  logic        imm_en,
  input  logic [7:0]  imm8,
  input  logic [3:0]  rot4,
  input  logic [1:0]  shift_type,
  input  logic [4:0]  shift_imm,
  input  logic        shift_by_reg,
  input  logic [4:0]  cmd_in,
  input  logic        carry_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] src1,
  output logic [31:0] src2,
  output logic        src2shift_carry,
  output logic        was_shifted,
  output logic [4:0]  CTRL_cmd
);

  state_e      state_q, state_d;
  operand_t    op_q, op_d;
  logic [31:0] src1_q, src1_d;
  logic [31:0] src2_q, src2_d;
  logic        carry_q, carry_d;
  logic        shifted_q, shifted_d;
  logic [4:0]  cmd_q, cmd_d;

  logic [31:0] sh_value;
  shift_type_e sh_type;
  logic [7:0]  sh_amount;
  logic        sh_cin;
  logic        sh_is_reg;
  logic [31:0] sh_result;
  logic        sh_carry;
  logic        sh_shifted;
  logic        accept;

  // Ready in IDLE, or in HOLD when the current result leaves this cycle.
  assign in_ready  = !RESET && ((state_q == ST_IDLE) ||
                                ((state_q == ST_HOLD) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_HOLD);

  // Shifter operands: captured bundle in REGSHIFT, live inputs otherwise.
  always_comb begin
    sh_value  = rm_val;
    sh_type   = shift_type_e'(shift_type);
    sh_amount = {3'b000, shift_imm};
    sh_cin    = carry_in;
    sh_is_reg = 1'b0;
    if (state_q == ST_REGSHIFT) begin
      sh_value  = op_q.rm;
      sh_type   = op_q.shift_type;
      sh_amount = op_q.rs;
      sh_cin    = op_q.cin;
      sh_is_reg = 1'b1;
    end else if (imm_en) begin
      sh_value  = {24'd0, imm8};
      sh_type   = SH_ROR;
      sh_amount = {3'b000, rot4, 1'b0};
      sh_is_reg = 1'b1;
    end
  end

  barrel_shifter u_shifter (
    .value      (sh_value),
    .shift_type (sh_type),
    .amount     (sh_amount),
    .carry_in   (sh_cin),
    .is_reg     (sh_is_reg),
    .result     (sh_result),
    .carry      (sh_carry),
    .shifted    (sh_shifted)
  );

  // Next-state and output-register update for the handshake FSM.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    carry_d   = carry_q;
    shifted_d = shifted_q;
    cmd_d     = cmd_q;
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
          if (shift_by_reg && !imm_en) begin
            op_d = '{rn: rn_val, rm: rm_val, rs: rs_val,
                     shift_type: shift_type_e'(shift_type),
                     cmd: cmd_in, cin: carry_in};
            state_d = ST_REGSHIFT;
          end else begin
            src1_d    = rn_val;
            src2_d    = sh_result;
            carry_d   = sh_carry;
            shifted_d = sh_shifted;
            cmd_d     = cmd_in;
            state_d   = ST_HOLD;
          end
        end else if ((state_q == ST_HOLD) && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_REGSHIFT: begin
        src1_d    = op_q.rn;
        src2_d    = sh_result;
        carry_d   = sh_carry;
        shifted_d = sh_shifted;
        cmd_d     = op_q.cmd;
        state_d   = ST_HOLD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (RESET) begin
      state_q   <= ST_IDLE;
      op_q      <= OPERAND_RESET;
      src1_q    <= 32'd0;
      src2_q    <= 32'd0;
      carry_q   <= 1'b0;
      shifted_q <= 1'b0;
      cmd_q     <= 5'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      carry_q   <= carry_d;
      shifted_q <= shifted_d;
      cmd_q     <= cmd_d;
    end
  end

  assign src1            = src1_q;
  assign src2            = src2_q;
  assign src2shift_carry = carry_q;
  assign was_shifted     = shifted_q;
  assign CTRL_cmd        = cmd_q;

endmodule
